i2s_dac_tx: RTL and testbench

- Master-mode I2S transmitter for the codec DAC path.
- Accepts stereo 24-bit samples on two Avalon-ST style sinks (left and right) with valid/ready handshakes.
- Generates BCLK and DACLRCK, and serialises samples MSB-first on DACDAT.
- Sits between the effect chain output (echo) and the codec pins. It is the producer-side counterpart of the ADC capture path.

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 47 ++++
 rtl/i2s_dac_tx.sv | 203 ++++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults, FSM state encoding and slot-position constants
// for the I2S DAC transmitter.
package i2s_pkg;

  localparam int I2S_DATA_W    = 24;
  localparam int I2S_SLOT_W    = 32;
  localparam int I2S_BCLK_HALF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Slot positions: bit 0 of each slot is the one-BCLK I2S delay after LRCK moves.
  localparam int FIRST_DATA_BIT = 1;
  localparam int LAST_DATA_BIT  = I2S_DATA_W;

  function automatic logic in_data_window(input int k, input int data_w);
    return (k >= FIRST_DATA_BIT) && (k <= data_w);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides i_clk down to BCLK and flags the cycles on which
// BCLK toggles falling (fall_tick) or rising (rise_tick).
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_fall_tick,
  output logic o_rise_tick
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term_s;

  // Divider next state: toggle BCLK at terminal count.
  always_comb begin
    term_s = (div_q == DIV_LAST);
    if (term_s) begin
      div_d  = {DIV_W{1'b0}};
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      bclk_d = bclk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q  <= {DIV_W{1'b0}};
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign o_bclk      = bclk_q;
  assign o_fall_tick = term_s & bclk_q;
  assign o_rise_tick = term_s & ~bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: master-mode I2S transmitter with one-deep left/right holding registers.
// Defining I2S_DAC_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W    = I2S_DATA_W,
  parameter int SLOT_W    = I2S_SLOT_W,
  parameter int BCLK_HALF = I2S_BCLK_HALF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_l_data,
  input  logic              i_l_valid,
  output logic              o_l_ready,
  input  logic [DATA_W-1:0] i_r_data,
  input  logic              i_r_valid,
  output logic              o_r_ready,
  output logic              o_bclk,
  output logic              o_daclrck,
  output logic              o_dacdat,
  output logic              o_underrun
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       o_underrun_cnt
`endif
);

  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              bclk_s, fall_tick_s, rise_tick_s;
  logic              boundary_s, both_full_s, load_s, l_take_s, r_take_s;
  logic [CNT_W-1:0]  nxt_cnt_s, k_s;
  logic              nxt_lrck_s, bit_s, in_win_s;
  logic [IDX_W-1:0]  idx_s;

  logic [DATA_W-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;
  logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              l_full_q, l_full_d, r_full_q, r_full_d;
  logic              l_ready_q, l_ready_d, r_ready_q, r_ready_d;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stage_lrck_q, stage_lrck_d, stage_dat_q, stage_dat_d;
  logic              lrck_q, lrck_d, dat_q, dat_d, underrun_q, underrun_d;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_bclk      (bclk_s),
    .o_fall_tick (fall_tick_s),
    .o_rise_tick (rise_tick_s)
  );

  // Handshake capture and frame-boundary transfer from holding to frame registers.
  always_comb begin
    l_take_s    = i_l_valid & l_ready_q;
    r_take_s    = i_r_valid & r_ready_q;
    boundary_s  = fall_tick_s & (bit_cnt_q == CNT_LAST);
    both_full_s = l_full_q & r_full_q;
    load_s      = boundary_s & ((state_q == ST_RUN) | both_full_s);
    underrun_d  = boundary_s & (state_q == ST_RUN) & ~both_full_s;

    l_hold_d = l_take_s ? i_l_data : l_hold_q;
    r_hold_d = r_take_s ? i_r_data : r_hold_q;

    // A write only lands in an empty register, so it wins over the load's clear.
    if (l_take_s) begin
      l_full_d = 1'b1;
    end else if (load_s) begin
      l_full_d = 1'b0;
    end else begin
      l_full_d = l_full_q;
    end
    if (r_take_s) begin
      r_full_d = 1'b1;
    end else if (load_s) begin
      r_full_d = 1'b0;
    end else begin
      r_full_d = r_full_q;
    end
    l_ready_d = ~l_full_d;
    r_ready_d = ~r_full_d;

    if (load_s) begin
      frame_l_d = l_full_q ? l_hold_q : {DATA_W{1'b0}};
      frame_r_d = r_full_q ? r_hold_q : {DATA_W{1'b0}};
    end else begin
      frame_l_d = frame_l_q;
      frame_r_d = frame_r_q;
    end
  end

  // FSM: leave IDLE only when a boundary finds both channels loaded.
  always_comb begin
    case (state_q)
      ST_IDLE: state_d = (boundary_s & both_full_s) ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot mapping: stage the next bit on BCLK rise, launch it on BCLK fall.
  always_comb begin
    nxt_cnt_s  = (bit_cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : (bit_cnt_q + CNT_ONE);
    nxt_lrck_s = (nxt_cnt_s >= SLOT_LEN);
    k_s        = nxt_lrck_s ? (nxt_cnt_s - SLOT_LEN) : nxt_cnt_s;
    idx_s      = IDX_W'(DATA_W - int'(k_s));
    in_win_s   = in_data_window(int'(k_s), DATA_W);
    bit_s      = nxt_lrck_s ? frame_r_q[idx_s] : frame_l_q[idx_s];

    if (rise_tick_s) begin
      stage_lrck_d = nxt_lrck_s;
      stage_dat_d  = (state_q == ST_RUN) & in_win_s & bit_s;
    end else begin
      stage_lrck_d = stage_lrck_q;
      stage_dat_d  = stage_dat_q;
    end

    if (fall_tick_s) begin
      bit_cnt_d = nxt_cnt_s;
      lrck_d    = stage_lrck_q;
      dat_d     = stage_dat_q;
    end else begin
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      dat_d     = dat_q;
    end
  end

  // State registers; reset discards any frame in progress and held data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l_hold_q     <= {DATA_W{1'b0}};
      r_hold_q     <= {DATA_W{1'b0}};
      frame_l_q    <= {DATA_W{1'b0}};
      frame_r_q    <= {DATA_W{1'b0}};
      l_full_q     <= 1'b0;
      r_full_q     <= 1'b0;
      l_ready_q    <= 1'b0;
      r_ready_q    <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= {CNT_W{1'b0}};
      stage_lrck_q <= 1'b0;
      stage_dat_q  <= 1'b0;
      lrck_q       <= 1'b0;
      dat_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      l_hold_q     <= l_hold_d;
      r_hold_q     <= r_hold_d;
      frame_l_q    <= frame_l_d;
      frame_r_q    <= frame_r_d;
      l_full_q     <= l_full_d;
      r_full_q     <= r_full_d;
      l_ready_q    <= l_ready_d;
      r_ready_q    <= r_ready_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stage_lrck_q <= stage_lrck_d;
      stage_dat_q  <= stage_dat_d;
      lrck_q       <= lrck_d;
      dat_q        <= dat_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_bclk     = bclk_s;
  assign o_daclrck  = lrck_q;
  assign o_dacdat   = dat_q;
  assign o_underrun = underrun_q;
  assign o_l_ready  = l_ready_q;
  assign o_r_ready  = r_ready_q;

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun count.
  always_comb begin
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underrun counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign o_underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized and directed stimulus; a frame-level reference model
// queues expected stereo frames and a serial monitor reassembles and compares them.
module tb_i2s_dac_tx;

  localparam int DW        = 24;
  localparam int SW        = 32;
  localparam int BH        = 8;
  localparam int FRAME_CYC = 2 * SW * 2 * BH;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] l_data, r_data;
  logic          l_valid, r_valid;
  logic          o_l_ready, o_r_ready, o_bclk, o_daclrck, o_dacdat, o_underrun;
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
  logic [15:0]   o_underrun_cnt;
`endif

  always #10 clk = ~clk;

  i2s_dac_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_HALF(BH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_l_data  (l_data),
    .i_l_valid (l_valid),
    .o_l_ready (o_l_ready),
    .i_r_data  (r_data),
    .i_r_valid (r_valid),
    .o_r_ready (o_r_ready),
    .o_bclk    (o_bclk),
    .o_daclrck (o_daclrck),
    .o_dacdat  (o_dacdat),
    .o_underrun(o_underrun)
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(o_underrun_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (frame level).
  frame_t        exp_q[$];
  int            e_cnt = 0;
  bit            m_run, m_full_l, m_full_r;
  logic [DW-1:0] m_hold_l, m_hold_r;
  bit            exp_ready_l, exp_ready_r, exp_underrun;
  int            exp_ucnt;

  // Monitor state.
  logic          dat_bits[64];
  logic          lrck_bits[64];
  int            rise_n = 0;
  logic          prev_bclk = 1'b0;
  int            frames_done = 0;
  logic [DW-1:0] last_l = '0, last_r = '0;
  int            dut_under = 0;
  int            dut_l_hs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, e_cnt);
    end
  endtask

  task automatic model_step();
    bit tl, tr;
    frame_t f;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      e_cnt = 0; m_run = 0; m_full_l = 0; m_full_r = 0;
      exp_ready_l = 0; exp_ready_r = 0; exp_underrun = 0; exp_ucnt = 0;
    end else begin
      tl = l_valid && exp_ready_l;
      tr = r_valid && exp_ready_r;
      exp_underrun = 0;
      if ((e_cnt % FRAME_CYC) == FRAME_CYC - 1) begin
        f = '0;
        if (m_run || (m_full_l && m_full_r)) begin
          exp_underrun = m_run && !(m_full_l && m_full_r);
          if (m_full_l) f.l = m_hold_l;
          if (m_full_r) f.r = m_hold_r;
          m_full_l = 0; m_full_r = 0; m_run = 1;
        end
        exp_q.push_back(f);
        if (exp_underrun && exp_ucnt < 65535) exp_ucnt++;
      end
      if (tl) begin m_full_l = 1; m_hold_l = l_data; end
      if (tr) begin m_full_r = 1; m_hold_r = r_data; end
      exp_ready_l = !m_full_l;
      exp_ready_r = !m_full_r;
      e_cnt++;
    end
  endtask

  task automatic frame_check();
    logic [DW-1:0] gl, gr;
    int pad_ones, lr_bad, k;
    frame_t f;
    gl = '0; gr = '0; pad_ones = 0; lr_bad = 0;
    for (int s = 0; s < 64; s++) begin
      k = s % SW;
      if (lrck_bits[s] !== (s >= SW)) lr_bad++;
      if (k >= 1 && k <= DW) begin
        if (s < SW) gl[DW-k] = dat_bits[s];
        else        gr[DW-k] = dat_bits[s];
      end else if (dat_bits[s] !== 1'b0) begin
        pad_ones++;
      end
    end
    last_l = gl; last_r = gr;
    frames_done++;
    if (exp_q.size() == 0) begin
      chk("frame_queue_empty", 32'd0, 32'd1);
    end else begin
      f = exp_q.pop_front();
      chk("frame_left", gl, f.l);
      chk("frame_right", gr, f.r);
    end
    chk("pad_bits_zero", pad_ones, 0);
    chk("lrck_pattern", lr_bad, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: per-cycle control checks and serial frame reassembly on BCLK rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_outputs", {26'd0, o_bclk, o_daclrck, o_dacdat, o_underrun, o_l_ready, o_r_ready}, 32'd0);
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
        chk("reset_underrun_cnt", o_underrun_cnt, 32'd0);
`endif
        prev_bclk = 1'b0;
        rise_n = 0;
      end else begin
        chk("bclk", o_bclk, (e_cnt / BH) % 2);
        chk("l_ready", o_l_ready, exp_ready_l);
        chk("r_ready", o_r_ready, exp_ready_r);
        chk("underrun", o_underrun, exp_underrun);
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt", o_underrun_cnt, exp_ucnt);
`endif
        if (o_underrun) dut_under++;
        if (o_bclk && !prev_bclk) begin
          if (rise_n == 0) chk("first_bclk_rise", e_cnt, 8);
          dat_bits[rise_n % 64]  = o_dacdat;
          lrck_bits[rise_n % 64] = o_daclrck;
          if ((rise_n % 64) == 63) frame_check();
          rise_n++;
        end
        prev_bclk = o_bclk;
      end
    end
  end

  // Handshake probe: inputs and ready are settled between negedge and posedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && l_valid && o_l_ready) dut_l_hs++;
    end
  end

  task automatic run_to_mod(input int m);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((e_cnt % FRAME_CYC) != m) && (n < 2 * FRAME_CYC + 4));
    if ((e_cnt % FRAME_CYC) != m) chk("wait_timeout", e_cnt % FRAME_CYC, m);
  endtask

  task automatic pulse_l(input logic [DW-1:0] d);
    l_valid = 1'b1; l_data = d;
    @(negedge clk);
    l_valid = 1'b0;
  endtask

  task automatic pulse_r(input logic [DW-1:0] d);
    r_valid = 1'b1; r_data = d;
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, h0;
    logic [DW-1:0] r1, r2, r3, l2, l4, r4;
    rst = 1'b1; l_valid = 1'b0; r_valid = 1'b0; l_data = '0; r_data = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Single stereo frame, accepted in frame 0, transmitted in frame 1.
    @(negedge clk);
    l_valid = 1'b1; l_data = 24'hA5A5A5;
    r_valid = 1'b1; r_data = 24'h3C3C3C;
    @(negedge clk);
    l_valid = 1'b0; r_valid = 1'b0;
    run_to_mod(0);
    run_to_mod(0);
    chk("single_left", last_l, 24'hA5A5A5);
    chk("single_right", last_r, 24'h3C3C3C);

    // Randomized sparse traffic.
    for (int i = 0; i < 5 * FRAME_CYC; i++) begin
      l_valid = ($urandom_range(0, 99) < 3);
      r_valid = ($urandom_range(0, 99) < 3);
      l_data = DW'($urandom);
      r_data = DW'($urandom);
      @(negedge clk);
    end
    l_valid = 1'b0; r_valid = 1'b0;

    // Backpressure: valid held high, exactly one accept per frame.
    run_to_mod(0);
    l_valid = 1'b1; r_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      h0 = dut_l_hs;
      for (int c = 0; c < FRAME_CYC; c++) begin
        l_data = DW'($urandom);
        r_data = DW'($urandom);
        @(negedge clk);
      end
      chk("backpressure_one_per_frame", dut_l_hs - h0, 1);
    end

    // Underrun: right only for one frame.
    l_valid = 1'b0;
    r1 = DW'($urandom); r2 = DW'($urandom); r3 = DW'($urandom); l2 = DW'($urandom);
    u0 = dut_under;
    pulse_r(r1);
    run_to_mod(0);
    chk("underrun_once", dut_under - u0, 1);

    // Boundary race: left handshake exactly on the boundary edge.
    u0 = dut_under;
    pulse_r(r2);
    run_to_mod(FRAME_CYC - 1);
    pulse_l(l2);
    chk("race_underrun", dut_under - u0, 1);
    chk("underrun_left_zero", last_l, 24'h0);
    chk("underrun_right_data", last_r, r1);
    pulse_r(r3);
    run_to_mod(0);
    chk("race_frame_left_zero", last_l, 24'h0);
    chk("race_frame_right", last_r, r2);
    run_to_mod(0);
    chk("race_sample_next_frame", last_l, l2);
    chk("race_next_right", last_r, r3);

    // Reset mid-frame at bit_cnt = 40, then IDLE needs both channels.
    run_to_mod(650);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    l4 = DW'($urandom); r4 = DW'($urandom);
    u0 = dut_under;
    pulse_l(l4);
    run_to_mod(0);
    chk("post_reset_frame0_zero", last_l, 24'h0);
    pulse_r(r4);
    run_to_mod(0);
    chk("idle_left_not_sent", last_l, 24'h0);
    chk("idle_no_underrun", dut_under - u0, 0);
    run_to_mod(0);
    chk("post_reset_left", last_l, l4);
    chk("post_reset_right", last_r, r4);

    chk("frames_seen", (frames_done >= 15) ? 32'd1 : 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
